scariv_dcache_bank_arbiter: RTL and testbench

Per-bank request arbiter in front of the banked L1 data cache. It collects read/write tag-data requests from the refill path and the LSU/STQ requesters and decodes the target bank from the physical address. Each cycle it grants at most one requester per bank and delivers the winner through a one-entry registered output slot per bank with a valid/ready handshake. The refill requester has fixed top priority, the remaining requesters are served round-robin, and an optional starvation guard bounds the waiting time of any requester.

---
 rtl/scariv_dcache_bank_arbiter.sv | 149 ++++++++++++++
 tb/tb_scariv_dcache_bank_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/scariv_dcache_bank_arbiter.sv
// Per-bank request arbiter for the banked L1 data cache: fixed refill priority, round-robin LSU/STQ.
// Optional starvation guard enabled by defining SCARIV_DCACHE_ARB_STARVE_EN.
module scariv_dcache_bank_arbiter #(
    parameter int REQ_NUM      = 4,
    parameter int BANKS        = 2,
    parameter int DATA_W       = 128,
    parameter int PADDR_W      = 56,
    parameter int STARVE_LIMIT = 8,
    localparam int IW          = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [REQ_NUM-1:0]               i_req_valid,
    input  logic [REQ_NUM-1:0][PADDR_W-1:0]  i_req_paddr,
    input  logic [REQ_NUM-1:0]               i_req_we,
    input  logic [REQ_NUM-1:0][DATA_W-1:0]   i_req_wdata,
    output logic [REQ_NUM-1:0]               o_req_ready,
    output logic [BANKS-1:0]                 o_bank_valid,
    output logic [BANKS-1:0][IW-1:0]         o_bank_req_id,
    output logic [BANKS-1:0][PADDR_W-1:0]    o_bank_paddr,
    output logic [BANKS-1:0]                 o_bank_we,
    output logic [BANKS-1:0][DATA_W-1:0]     o_bank_wdata,
    input  logic [BANKS-1:0]                 i_bank_ready
);

    localparam int OFF = $clog2(DATA_W / 8);
    localparam int BW  = (BANKS > 1) ? $clog2(BANKS) : 1;

    function automatic int bank_of(input logic [PADDR_W-1:0] a);
        logic [PADDR_W-1:0] sh;
        sh = a >> OFF;
        if (BANKS == 1) return 0;
        return int'(sh[BW-1:0]);
    endfunction

    logic [BANKS-1:0]          slot_free;
    logic [BANKS-1:0]          gnt_v;
    logic [BANKS-1:0][IW-1:0]  gnt_id;
    logic [BANKS-1:0][IW-1:0]  rr_ptr;
    logic [BANKS-1:0][IW-1:0]  rr_nxt;
    logic [REQ_NUM-1:0]        starved;

    assign slot_free = ~o_bank_valid | i_bank_ready;

`ifdef SCARIV_DCACHE_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [REQ_NUM-1:0][CW-1:0] wait_cnt;

    always_comb begin
        starved = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            starved[k] = (wait_cnt[k] == CW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt <= '0;
        end else begin
            for (int k = 0; k < REQ_NUM; k++) begin
                if (!i_req_valid[k] || o_req_ready[k]) begin
                    wait_cnt[k] <= '0;
                end else if (wait_cnt[k] != CW'(STARVE_LIMIT)) begin
                    wait_cnt[k] <= wait_cnt[k] + CW'(1);
                end
            end
        end
    end
`else
    assign starved = '0;
`endif

    always_comb begin : arb_p
        logic found;
        int   win;
        int   idx;
        found       = 1'b0;
        win         = 0;
        idx         = 0;
        o_req_ready = '0;
        gnt_v       = '0;
        gnt_id      = '0;
        rr_nxt      = rr_ptr;
        for (int b = 0; b < BANKS; b++) begin
            found = 1'b0;
            win   = 0;
            if (i_reset_n && slot_free[b]) begin
                for (int k = 0; k < REQ_NUM; k++) begin
                    if (!found && starved[k] && i_req_valid[k] &&
                        bank_of(i_req_paddr[k]) == b) begin
                        found = 1'b1;
                        win   = k;
                    end
                end
                if (!found && i_req_valid[0] &&
                    bank_of(i_req_paddr[0]) == b) begin
                    found = 1'b1;
                    win   = 0;
                end
                // Scan 1..REQ_NUM-1 starting at the pointer, wrapping past index 0.
                for (int off = 0; off < REQ_NUM - 1; off++) begin
                    idx = int'(rr_ptr[b]) + off;
                    if (idx >= REQ_NUM) idx = idx - (REQ_NUM - 1);
                    if (!found && i_req_valid[idx] &&
                        bank_of(i_req_paddr[idx]) == b) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
            end
            if (found) begin
                o_req_ready[win] = 1'b1;
                gnt_v[b]         = 1'b1;
                gnt_id[b]        = IW'(win);
                if (win != 0) begin
                    rr_nxt[b] = (win == REQ_NUM - 1) ? IW'(1) : IW'(win + 1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_bank_valid  <= '0;
            o_bank_req_id <= '0;
            o_bank_paddr  <= '0;
            o_bank_we     <= '0;
            o_bank_wdata  <= '0;
            for (int b = 0; b < BANKS; b++) begin
                rr_ptr[b] <= IW'(1);
            end
        end else begin
            rr_ptr <= rr_nxt;
            for (int b = 0; b < BANKS; b++) begin
                if (gnt_v[b]) begin
                    o_bank_valid[b]  <= 1'b1;
                    o_bank_req_id[b] <= gnt_id[b];
                    o_bank_paddr[b]  <= i_req_paddr[gnt_id[b]];
                    o_bank_we[b]     <= i_req_we[gnt_id[b]];
                    o_bank_wdata[b]  <= i_req_wdata[gnt_id[b]];
                end else if (i_bank_ready[b]) begin
                    o_bank_valid[b] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_scariv_dcache_bank_arbiter.sv
// Directed bench for scariv_dcache_bank_arbiter (REQ_NUM=4, BANKS=2, DATA_W=128).
// Bank select is paddr[4]; starvation expectations follow SCARIV_DCACHE_ARB_STARVE_EN.
module tb_scariv_dcache_bank_arbiter;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [3:0]              req_valid;
    logic [3:0][55:0]        req_paddr;
    logic [3:0]              req_we;
    logic [3:0][127:0]       req_wdata;
    logic [3:0]              req_ready;
    logic [1:0]              bank_valid;
    logic [1:0][1:0]         bank_id;
    logic [1:0][55:0]        bank_paddr;
    logic [1:0]              bank_we;
    logic [1:0][127:0]       bank_wdata;
    logic [1:0]              bank_ready;

    int passed = 0;
    int total  = 0;

    scariv_dcache_bank_arbiter dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_req_valid   (req_valid),
        .i_req_paddr   (req_paddr),
        .i_req_we      (req_we),
        .i_req_wdata   (req_wdata),
        .o_req_ready   (req_ready),
        .o_bank_valid  (bank_valid),
        .o_bank_req_id (bank_id),
        .o_bank_paddr  (bank_paddr),
        .o_bank_we     (bank_we),
        .o_bank_wdata  (bank_wdata),
        .i_bank_ready  (bank_ready)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        req_valid  = 4'hF;
        req_paddr  = '0;
        req_we     = '0;
        req_wdata  = '0;
        bank_ready = 2'b11;
        repeat (2) @(negedge clk);
        total++; if (bank_valid !== 2'b00) $display("FAIL reset_valid got %h want 0", bank_valid); else passed++;
        total++; if (bank_id !== 4'h0) $display("FAIL reset_id got %h want 0", bank_id); else passed++;
        total++; if (bank_paddr !== '0) $display("FAIL reset_paddr got %h want 0", bank_paddr); else passed++;
        total++; if (bank_we !== 2'b00) $display("FAIL reset_we got %h want 0", bank_we); else passed++;
        total++; if (bank_wdata !== '0) $display("FAIL reset_wdata got %h want 0", bank_wdata); else passed++;
        total++; if (req_ready !== 4'h0) $display("FAIL reset_ready got %h want 0", req_ready); else passed++;
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        req_paddr[2] = 56'h10;
        req_we[2]    = 1'b0;
        req_valid    = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL single_ready got %h want 4", req_ready); else passed++;
        @(negedge clk);
        total++; if (bank_valid !== 2'b10) $display("FAIL single_valid got %h want 2", bank_valid); else passed++;
        total++; if (bank_id[1] !== 2'd2) $display("FAIL single_id got %0d want 2", bank_id[1]); else passed++;
        total++; if (bank_paddr[1] !== 56'h10) $display("FAIL single_paddr got %h want 10", bank_paddr[1]); else passed++;
        total++; if (bank_we[1] !== 1'b0) $display("FAIL single_we got %b want 0", bank_we[1]); else passed++;
        req_valid = '0;
        @(negedge clk);
        total++; if (bank_valid !== 2'b00) $display("FAIL single_drain got %h want 0", bank_valid); else passed++;
    endtask

    task automatic test_round_robin();
        int exp_id[6] = '{1, 2, 3, 1, 2, 3};
        req_paddr[1] = 56'h00;
        req_paddr[2] = 56'h20;
        req_paddr[3] = 56'h40;
        req_we       = '0;
        req_valid    = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (req_ready !== 4'(1 << exp_id[i]))
                $display("FAIL rr_ready[%0d] got %h want %h", i, req_ready, 4'(1 << exp_id[i]));
            else passed++;
            if (i > 0) begin
                total++;
                if ({bank_valid[0], bank_id[0]} !== {1'b1, 2'(exp_id[i-1])})
                    $display("FAIL rr_slot[%0d] got %b/%0d want 1/%0d", i, bank_valid[0], bank_id[0], exp_id[i-1]);
                else passed++;
            end
            @(negedge clk);
        end
        total++;
        if ({bank_valid[0], bank_id[0]} !== {1'b1, 2'd3})
            $display("FAIL rr_last got %b/%0d want 1/3", bank_valid[0], bank_id[0]);
        else passed++;
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        req_paddr[0] = 56'h00;
        req_paddr[1] = 56'h20;
        req_paddr[2] = 56'h60;
        req_valid    = 4'b0111;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL prio_r0 got %h want 1", req_ready); else passed++;
        @(negedge clk);
        total++; if (bank_id[0] !== 2'd0 || bank_valid[0] !== 1'b1) $display("FAIL prio_slot0 got %0d want 0", bank_id[0]); else passed++;
        req_valid[0] = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) $display("FAIL prio_r1 got %h want 2", req_ready); else passed++;
        @(negedge clk);
        total++; if (bank_id[0] !== 2'd1) $display("FAIL prio_slot1 got %0d want 1", bank_id[0]); else passed++;
        req_valid[1] = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL prio_r2 got %h want 4", req_ready); else passed++;
        @(negedge clk);
        total++; if (bank_id[0] !== 2'd2) $display("FAIL prio_slot2 got %0d want 2", bank_id[0]); else passed++;
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_two_banks();
        req_paddr[1] = 56'h00;
        req_paddr[3] = 56'h30;
        req_valid    = 4'b1010;
        #1;
        total++; if (req_ready !== 4'b1010) $display("FAIL dual_ready got %h want a", req_ready); else passed++;
        @(negedge clk);
        total++; if (bank_valid !== 2'b11) $display("FAIL dual_valid got %h want 3", bank_valid); else passed++;
        total++; if (bank_id !== {2'd3, 2'd1}) $display("FAIL dual_id got %h want d", bank_id); else passed++;
        req_valid = '0;
        @(negedge clk);
        total++; if (bank_valid !== 2'b00) $display("FAIL dual_drain got %h want 0", bank_valid); else passed++;
    endtask

    task automatic test_backpressure();
        logic [127:0] wd = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
        bank_ready   = 2'b10;
        req_paddr[1] = 56'h00;
        req_we[1]    = 1'b1;
        req_wdata[1] = wd;
        req_valid    = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) $display("FAIL bp_first got %h want 2", req_ready); else passed++;
        @(negedge clk);
        total++; if ({bank_valid[0], bank_id[0], bank_we[0]} !== {1'b1, 2'd1, 1'b1}) $display("FAIL bp_load got %b%0d%b want 1 1 1", bank_valid[0], bank_id[0], bank_we[0]); else passed++;
        req_paddr[2] = 56'h20;
        req_we[2]    = 1'b0;
        req_valid    = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (req_ready !== 4'b0000) $display("FAIL bp_hold_ready[%0d] got %h want 0", i, req_ready); else passed++;
            @(negedge clk);
            total++;
            if ({bank_valid[0], bank_id[0], bank_paddr[0], bank_wdata[0]} !== {1'b1, 2'd1, 56'h00, wd})
                $display("FAIL bp_hold_slot[%0d] got %b/%0d/%h want 1/1/0", i, bank_valid[0], bank_id[0], bank_paddr[0]);
            else passed++;
        end
        bank_ready = 2'b11;
        #1;
        total++; if (req_ready !== 4'b0100) $display("FAIL bp_release got %h want 4", req_ready); else passed++;
        @(negedge clk);
        total++;
        if ({bank_valid[0], bank_id[0], bank_we[0], bank_paddr[0]} !== {1'b1, 2'd2, 1'b0, 56'h20})
            $display("FAIL bp_reload got %b/%0d/%b/%h want 1/2/0/20", bank_valid[0], bank_id[0], bank_we[0], bank_paddr[0]);
        else passed++;
        req_valid = '0;
        req_we    = '0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int first = -1;
        int exp_first;
`ifdef SCARIV_DCACHE_ARB_STARVE_EN
        exp_first = 8;
`else
        exp_first = -1;
`endif
        req_paddr[0] = 56'h00;
        req_paddr[1] = 56'h20;
        req_valid    = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (c == 0) begin
                total++; if (req_ready !== 4'b0001) $display("FAIL starve_c0 got %h want 1", req_ready); else passed++;
            end
            if (req_ready[1] && first < 0) first = c;
            @(negedge clk);
            if (first >= 0) req_valid[1] = 1'b0;
        end
        total++; if (first !== exp_first) $display("FAIL starve_grant got %0d want %0d", first, exp_first); else passed++;
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        req_paddr[1] = 56'h00;
        req_valid    = 4'b0010;
        @(negedge clk);
        total++; if (bank_valid[0] !== 1'b1) $display("FAIL mrst_load got %b want 1", bank_valid[0]); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bank_valid !== 2'b00) $display("FAIL mrst_clear got %h want 0", bank_valid); else passed++;
        total++; if (req_ready !== 4'h0) $display("FAIL mrst_ready got %h want 0", req_ready); else passed++;
        @(negedge clk);
        rst_n        = 1'b1;
        req_paddr[2] = 56'h20;
        req_paddr[3] = 56'h40;
        req_valid    = 4'b1110;
        #1;
        total++; if (req_ready !== 4'b0010) $display("FAIL mrst_rrptr got %h want 2", req_ready); else passed++;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_priority();
        test_two_banks();
        test_backpressure();
        test_starvation();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
